// File: rtl/dsp_wdata_channel_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dsp_wdata_channel_pkg : W beat payload type and route FSM encoding.      |
// | Optional WSTRB lane: DSP_WDATA_STRB_EN.            Rev 1.0 - initial     |
// +--------------------------------------------------------------------------+
package dsp_wdata_channel_pkg;

  localparam int unsigned DSP_DATA_W = 32;

  typedef struct packed {
    logic [DSP_DATA_W-1:0]   wdata;
`ifdef DSP_WDATA_STRB_EN
    logic [DSP_DATA_W/8-1:0] wstrb;
`endif
    logic                    wlast;
  } dsp_w_beat_t;

  typedef logic [0:0] dsp_w_state_t;
  localparam dsp_w_state_t ST_IDLE  = 1'b0;
  localparam dsp_w_state_t ST_BURST = 1'b1;

endpackage
`default_nettype wire

// File: rtl/dsp_wdata_channel_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dsp_wdata_channel_if : AW route push, master W and slave W signals.      |
// | Optional WSTRB lane: DSP_WDATA_STRB_EN.            Rev 1.0 - initial     |
// +--------------------------------------------------------------------------+
interface dsp_wdata_channel_if #(
  parameter int SLV_AMT         = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int SLV_ID_W        = $clog2(SLV_AMT),
  parameter int DSP_WDATA_DEPTH = 16
);
  localparam int OUTST_W = $clog2(DSP_WDATA_DEPTH + 1);

  logic [SLV_ID_W-1:0]   dsp_AW_slv_id_i;
  logic                  dsp_AW_push_i;
  logic                  dsp_AW_ready_o;
  logic [DATA_WIDTH-1:0] m_WDATA_i;
  logic                  m_WLAST_i;
  logic                  m_WVALID_i;
  logic                  m_WREADY_o;
  logic [DATA_WIDTH-1:0] sa_WDATA_o;
  logic                  sa_WLAST_o;
  logic [SLV_AMT-1:0]    sa_WVALID_o;
  logic [SLV_AMT-1:0]    sa_WREADY_i;
  logic [OUTST_W-1:0]    dsp_W_outst_o;
`ifdef DSP_WDATA_STRB_EN
  logic [DATA_WIDTH/8-1:0] m_WSTRB_i;
  logic [DATA_WIDTH/8-1:0] sa_WSTRB_o;
`endif

  modport slave (
`ifdef DSP_WDATA_STRB_EN
    input  m_WSTRB_i,
    output sa_WSTRB_o,
`endif
    input  dsp_AW_slv_id_i, dsp_AW_push_i, m_WDATA_i, m_WLAST_i, m_WVALID_i, sa_WREADY_i,
    output dsp_AW_ready_o, m_WREADY_o, sa_WDATA_o, sa_WLAST_o, sa_WVALID_o, dsp_W_outst_o
  );

  modport master (
`ifdef DSP_WDATA_STRB_EN
    output m_WSTRB_i,
    input  sa_WSTRB_o,
`endif
    output dsp_AW_slv_id_i, dsp_AW_push_i, m_WDATA_i, m_WLAST_i, m_WVALID_i, sa_WREADY_i,
    input  dsp_AW_ready_o, m_WREADY_o, sa_WDATA_o, sa_WLAST_o, sa_WVALID_o, dsp_W_outst_o
  );

endinterface
`default_nettype wire

// File: rtl/fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo : power-of-two synchronous FIFO; a push while full is taken only   |
// | when a pop frees the slot in the same cycle.       Rev 1.0 - initial     |
// +--------------------------------------------------------------------------+
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_push,
  input  wire logic [WIDTH-1:0] i_data,
  input  wire logic             i_pop,
  output logic                  o_push_ok,
  output logic                  o_pop_ok,
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_full,
  output logic [CNT_W-1:0]      o_count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_pop_ok  = i_pop & (r_count != '0);
  assign o_push_ok = i_push & (~o_full | o_pop_ok);
  assign o_data    = r_mem[r_rptr];
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (o_push_ok) r_wptr <= r_wptr + PTR_W'(1);
      if (o_pop_ok)  r_rptr <= r_rptr + PTR_W'(1);
      case ({o_push_ok, o_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (o_push_ok) r_mem[r_wptr] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/skid_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | skid_buffer : two-entry registered buffer, ready derived from occupancy. |
// |                                                    Rev 1.0 - initial     |
// +--------------------------------------------------------------------------+
module skid_buffer #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_valid,
  output logic                  o_ready,
  input  wire logic [WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  wire logic             i_ready,
  output logic [WIDTH-1:0]      o_data
);
  logic [WIDTH-1:0] r_mem [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_ready = ~rst & (r_cnt != 2'd2);
  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_mem[r_rptr];
  assign w_push  = i_valid & o_ready;
  assign w_pop   = o_valid & i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/dsp_wdata_channel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dsp_wdata_channel : routes master W bursts to the slave at the head of  |
// | the AW route queue. Optional WSTRB: DSP_WDATA_STRB_EN. Rev 1.0 - initial |
// +--------------------------------------------------------------------------+
module dsp_wdata_channel
  import dsp_wdata_channel_pkg::*;
#(
  parameter int SLV_AMT         = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int SLV_ID_W        = $clog2(SLV_AMT),
  parameter int DSP_WDATA_DEPTH = 16
) (
  input wire logic           ACLK_i,
  input wire logic           ARESET_i,
  dsp_wdata_channel_if.slave bus
);
  localparam int OUTST_W = $clog2(DSP_WDATA_DEPTH + 1);

  if (DATA_WIDTH != DSP_DATA_W) begin : g_width_chk
    $error("DATA_WIDTH must equal dsp_wdata_channel_pkg::DSP_DATA_W");
  end

  dsp_w_beat_t         w_in_beat;
  dsp_w_beat_t         w_fwd_beat;
  logic                w_fwd_valid;
  logic                w_fwd_ready;
  logic [SLV_ID_W-1:0] w_head;
  logic                w_full;
  logic [OUTST_W-1:0]  w_outst;
  logic                w_push_ok;
  logic                w_pop_ok;
  logic                w_pop;
  logic [SLV_AMT-1:0]  w_sel;
  logic                w_route_en;
  dsp_w_state_t        r_state;
  dsp_w_state_t        w_state_nxt;

  always_comb begin
    w_in_beat       = '0;
    w_in_beat.wdata = bus.m_WDATA_i;
`ifdef DSP_WDATA_STRB_EN
    w_in_beat.wstrb = bus.m_WSTRB_i;
`endif
    w_in_beat.wlast = bus.m_WLAST_i;
  end

  skid_buffer #(
    .WIDTH ($bits(dsp_w_beat_t))
  ) u_skid (
    .clk     (ACLK_i),
    .rst     (ARESET_i),
    .i_valid (bus.m_WVALID_i),
    .o_ready (bus.m_WREADY_o),
    .i_data  (w_in_beat),
    .o_valid (w_fwd_valid),
    .i_ready (w_fwd_ready),
    .o_data  (w_fwd_beat)
  );

  fifo #(
    .WIDTH (SLV_ID_W),
    .DEPTH (DSP_WDATA_DEPTH),
    .CNT_W (OUTST_W)
  ) u_route_q (
    .clk       (ACLK_i),
    .rst       (ARESET_i),
    .i_push    (bus.dsp_AW_push_i),
    .i_data    (bus.dsp_AW_slv_id_i),
    .i_pop     (w_pop),
    .o_push_ok (w_push_ok),
    .o_pop_ok  (w_pop_ok),
    .o_data    (w_head),
    .o_full    (w_full),
    .o_count   (w_outst)
  );

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Leave BURST only when the last queued burst completes with nothing arriving.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_push_ok) w_state_nxt = ST_BURST;
      ST_BURST: if (w_pop_ok && (w_outst == OUTST_W'(1)) && !w_push_ok) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_route_en = 1'b0;
    if ((r_state == ST_BURST) && !ARESET_i) w_route_en = 1'b1;
  end

  // A head index with no matching slave selects nothing, so the beat stalls.
  for (genvar s = 0; s < SLV_AMT; s++) begin : g_sel
    assign w_sel[s] = (w_head == SLV_ID_W'(s));
  end

  assign w_fwd_ready        = w_route_en & |(w_sel & bus.sa_WREADY_i);
  assign w_pop              = w_fwd_valid & w_fwd_ready & w_fwd_beat.wlast;
  assign bus.sa_WVALID_o    = {SLV_AMT{w_route_en & w_fwd_valid}} & w_sel;
  assign bus.sa_WDATA_o     = w_fwd_beat.wdata;
  assign bus.sa_WLAST_o     = w_fwd_beat.wlast;
`ifdef DSP_WDATA_STRB_EN
  assign bus.sa_WSTRB_o     = w_fwd_beat.wstrb;
`endif
  assign bus.dsp_AW_ready_o = ~w_full;
  assign bus.dsp_W_outst_o  = w_outst;

endmodule
`default_nettype wire

// File: tb/tb_dsp_wdata_channel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dsp_wdata_channel : queue-based reference model, directed scenarios  |
// | followed by randomized traffic.                    Rev 1.0 - initial     |
// +--------------------------------------------------------------------------+
module tb_dsp_wdata_channel;
  localparam int N  = 2;
  localparam int DW = 32;
  localparam int IW = 1;
  localparam int D  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dsp_wdata_channel_if #(.SLV_AMT(N), .DATA_WIDTH(DW), .SLV_ID_W(IW), .DSP_WDATA_DEPTH(D)) bus ();

  dsp_wdata_channel #(.SLV_AMT(N), .DATA_WIDTH(DW), .SLV_ID_W(IW), .DSP_WDATA_DEPTH(D)) dut (
    .ACLK_i   (clk),
    .ARESET_i (rst),
    .bus      (bus)
  );

`ifdef DSP_WDATA_STRB_EN
  initial bus.m_WSTRB_i = '1;
`endif

  typedef struct { logic [DW-1:0] d; bit l; } beat_t;
  beat_t sb[$];   // beats held between master and slaves
  int    rq[$];   // slave indices of bursts not yet completed
  int    vectors = 0;
  int    errors  = 0;
  bit    last_win;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [N-1:0] ev;
    ev = '0;
    if (rq.size() > 0 && sb.size() > 0 && rq[0] < N) ev[rq[0]] = 1'b1;
    check("sa_WVALID", bus.sa_WVALID_o, ev);
    check("AW_ready", bus.dsp_AW_ready_o, rq.size() < D);
    check("m_WREADY", bus.m_WREADY_o, !rst && sb.size() < 2);
    check("W_outst", bus.dsp_W_outst_o, rq.size());
    if (ev != '0) begin
      check("sa_WDATA", bus.sa_WDATA_o, sb[0].d);
      check("sa_WLAST", bus.sa_WLAST_o, sb[0].l);
    end
  endtask

  // One clock: derive the handshakes from the model, advance it, then compare.
  task automatic cycle();
    bit    fire, popq, pushq, win;
    int    pid;
    beat_t nb;
    fire = 1'b0;
    if (rq.size() > 0 && sb.size() > 0 && rq[0] < N) fire = bus.sa_WREADY_i[rq[0]];
    popq  = fire && sb[0].l;
    pushq = bus.dsp_AW_push_i && ((rq.size() - int'(popq)) < D);
    win   = bus.m_WVALID_i && (sb.size() < 2) && !rst;
    pid   = int'(bus.dsp_AW_slv_id_i);
    nb.d  = bus.m_WDATA_i;
    nb.l  = bus.m_WLAST_i;
    @(posedge clk);
    if (rst) begin
      sb.delete();
      rq.delete();
    end else begin
      if (fire)  void'(sb.pop_front());
      if (popq)  void'(rq.pop_front());
      if (pushq) rq.push_back(pid);
      if (win)   sb.push_back(nb);
    end
    last_win = win;
    #1;
    compare_model();
  endtask

  task automatic drive(bit push, int id, bit wv, logic [DW-1:0] d, bit l, logic [N-1:0] rdy);
    bus.dsp_AW_push_i   = push;
    bus.dsp_AW_slv_id_i = IW'(id);
    bus.m_WVALID_i      = wv;
    bus.m_WDATA_i       = d;
    bus.m_WLAST_i       = l;
    bus.sa_WREADY_i     = rdy;
  endtask

  initial begin
    bit            cv, cl;
    logic [DW-1:0] cd;

    drive(0, 0, 0, '0, 0, '1);
    rst = 1'b1;
    repeat (3) cycle();
    check("rst_outst", bus.dsp_W_outst_o, 0);
    check("rst_wvalid", bus.sa_WVALID_o, 0);
    check("rst_wready", bus.m_WREADY_o, 0);
    check("rst_awready", bus.dsp_AW_ready_o, 1);
    rst = 1'b0;
    #1;
    check("wready_after_rst", bus.m_WREADY_o, 1);

    // Single 4-beat burst to slave 1
    drive(1, 1, 1, 'hA0, 0, '1); cycle();
    check("t1_valid", bus.sa_WVALID_o, 2'b10);
    check("t1_outst", bus.dsp_W_outst_o, 1);
    check("t1_data0", bus.sa_WDATA_o, 'hA0);
    drive(0, 0, 1, 'hA1, 0, '1); cycle();
    drive(0, 0, 1, 'hA2, 0, '1); cycle();
    drive(0, 0, 1, 'hA3, 1, '1); cycle();
    check("t1_outst_mid", bus.dsp_W_outst_o, 1);
    check("t1_data3", bus.sa_WDATA_o, 'hA3);
    check("t1_last3", bus.sa_WLAST_o, 1);
    drive(0, 0, 0, '0, 0, '1); cycle();
    check("t1_outst_end", bus.dsp_W_outst_o, 0);
    check("t1_valid_end", bus.sa_WVALID_o, 2'b00);

    // W arrives before any route entry
    drive(0, 0, 1, 'hB0, 0, '1); cycle();
    drive(0, 0, 1, 'hB1, 1, '1); cycle();
    drive(0, 0, 0, '0, 0, '1); cycle();
    check("t3_wready_full", bus.m_WREADY_o, 0);
    check("t3_no_valid", bus.sa_WVALID_o, 2'b00);
    drive(1, 0, 0, '0, 0, '1); cycle();
    check("t3_release", bus.sa_WVALID_o, 2'b01);
    check("t3_data", bus.sa_WDATA_o, 'hB0);
    drive(0, 0, 0, '0, 0, '1); repeat (2) cycle();
    check("t3_outst_end", bus.dsp_W_outst_o, 0);

    // Back-to-back routes to slaves 0 then 1
    drive(1, 0, 1, 'hC0, 0, '1); cycle();
    drive(1, 1, 1, 'hC1, 1, '1); cycle();
    check("t2_peak", bus.dsp_W_outst_o, 2);
    check("t2_first", bus.sa_WVALID_o, 2'b01);
    drive(0, 0, 1, 'hC2, 0, '1); cycle();
    check("t2_second", bus.sa_WVALID_o, 2'b10);
    check("t2_data2", bus.sa_WDATA_o, 'hC2);
    drive(0, 0, 1, 'hC3, 1, '1); cycle();
    drive(0, 0, 0, '0, 0, '1); cycle();
    check("t2_outst_end", bus.dsp_W_outst_o, 0);

    // Slave 0 back-pressure mid-burst
    drive(1, 0, 1, 'hD0, 0, 2'b01); cycle();
    drive(0, 0, 1, 'hD1, 0, 2'b01); cycle();
    drive(0, 0, 1, 'hD2, 0, 2'b00); cycle();
    drive(0, 0, 1, 'hD3, 1, 2'b00); repeat (4) cycle();
    check("t4_hold_valid", bus.sa_WVALID_o, 2'b01);
    check("t4_hold_data", bus.sa_WDATA_o, 'hD1);
    drive(0, 0, 1, 'hD3, 1, 2'b01); repeat (2) cycle();
    drive(0, 0, 0, '0, 0, 2'b01); cycle();
    check("t4_outst_end", bus.dsp_W_outst_o, 0);

    // Reset after two beats of a four-beat burst
    drive(1, 1, 1, 'hE0, 0, '1); cycle();
    drive(0, 0, 1, 'hE1, 0, '1); cycle();
    drive(0, 0, 1, 'hE2, 0, '1); cycle();
    rst = 1'b1;
    drive(0, 0, 1, 'hE3, 1, '1); cycle();
    check("t5_outst", bus.dsp_W_outst_o, 0);
    check("t5_valid", bus.sa_WVALID_o, 2'b00);
    rst = 1'b0;
    drive(1, 0, 1, 'hF0, 0, '1); cycle();
    check("t5_reroute", bus.sa_WVALID_o, 2'b01);
    check("t5_data", bus.sa_WDATA_o, 'hF0);
    drive(0, 0, 1, 'hF1, 1, '1); cycle();
    drive(0, 0, 0, '0, 0, '1); cycle();
    check("t5_outst_end", bus.dsp_W_outst_o, 0);

    // Full route queue, push coinciding with a WLAST pop
    for (int i = 0; i < D; i++) begin
      drive(1, 1, 0, '0, 0, '1); cycle();
    end
    check("t6_full", bus.dsp_W_outst_o, 16);
    check("t6_awready", bus.dsp_AW_ready_o, 0);
    drive(0, 0, 1, 'h55, 1, '1); cycle();
    check("t6_awready_before", bus.dsp_AW_ready_o, 0);
    drive(1, 0, 0, '0, 0, '1); cycle();
    check("t6_keep16", bus.dsp_W_outst_o, 16);

    // Randomized traffic, with one reset pulse along the way
    cv = 1'b0; cd = '0; cl = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (!cv || last_win) begin
        cv = ($urandom_range(0, 3) != 0);
        cd = $urandom;
        cl = ($urandom_range(0, 2) == 0);
      end
      rst = (c == 700);
      drive($urandom_range(0, 3) == 0, $urandom_range(0, N - 1), cv, cd, cl, N'($urandom_range(0, 3)));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
`default_nettype wire
